wishbone_slave_decoder: RTL and testbench
=========================================

// Module: wishbone_slave_decoder
// PURPOSE
//  Slave-side counterpart of the bus arbiter. Takes the single granted-master bus (CYC/STB/WE/ADR/DAT/SEL)
//  and routes each transfer to one of up to 4 slaves, decoded from the top two address bits.
//  Returns the selected slave's read data and ACK/ERR to the master. Raises ERR for unmapped slaves
//  and, optionally, for slaves that never terminate the cycle (watchdog).
// PARAMETERS
//  ADDR_W   32   address width; slave index = ADR_I[ADDR_W-1 -: 2]
//  DATA_W   32   data width (SEL width = DATA_W/8)
//  NSLV     4    populated slaves, 1..4; an index >= NSLV is unmapped
//  TIMEOUT  255  watchdog limit in ACTIVE cycles, 1..65535 (used only with WB_DECODER_TIMEOUT_EN)
// PORTS
//  CLK      in   1           clock, all state on rising edge
//  RST      in   1           synchronous, active-high reset
//  CYC_I    in   1           bus cycle from arbiter (the muxed CYC)
//  STB_I    in   1           strobe from granted master
//  WE_I     in   1           write enable
//  ADR_I    in   ADDR_W      address
//  DAT_I    in   DATA_W      write data
//  SEL_I    in   DATA_W/8    byte selects
//  DAT_O    out  DATA_W      read data to master; 0 unless ACK_O is high
//  ACK_O    out  1           transfer acknowledge to master
//  ERR_O    out  1           transfer error to master
//  CYC_O    out  4           per-slave CYC, one-hot or 0
//  STB_O    out  4           per-slave STB, one-hot or 0
//  WE_O     out  1           broadcast WE_I
//  ADR_O    out  ADDR_W      broadcast ADR_I
//  DAT_SO   out  DATA_W      broadcast DAT_I
//  SEL_O    out  DATA_W/8    broadcast SEL_I
//  ACK_S    in   4           per-slave ACK
//  ERR_S    in   4           per-slave ERR
//  DAT_S    in   4*DATA_W    per-slave read data; slave k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: state=IDLE, sel_q=0, wdog=0. CYC_O, STB_O, ACK_O, ERR_O and DAT_O are all 0 while RST is high.
//  - FSM states: IDLE, ACTIVE, DECERR.
//    - IDLE: on CYC_I&STB_I, latch the index into sel_q.
//      - Mapped index -> ACTIVE.
//      - Unmapped index -> DECERR.
//      - No outputs are asserted in IDLE, so address-to-slave-strobe latency is 1 cycle.
//    - ACTIVE: CYC_O[sel_q]=CYC_I and STB_O[sel_q]=STB_I.
//      - ACK_O=ACK_S[sel_q] and ERR_O=ERR_S[sel_q], both combinational (same cycle).
//      - DAT_O=DAT_S[sel_q] when ACK_O is high.
//      - Exit on ACK_S|ERR_S of the selected slave -> IDLE.
//    - DECERR: no slave strobed; ERR_O=1 for exactly one cycle -> IDLE.
//  - Only the selected slave's ACK/ERR is honoured; responses on the other lanes are ignored.
//  - Selected slave asserts ACK and ERR together: ERR wins; ACK_O=0, DAT_O=0.
//  - CYC_I falls in ACTIVE or DECERR: abort to IDLE next edge, with no ACK_O/ERR_O, and clear wdog.
//  - Back-to-back transfers: STB_I still high after a termination is re-decoded from IDLE, so every transfer costs >=2 cycles.
//  - RST mid-transfer: immediate return to IDLE with outputs 0; an in-flight slave response is dropped.
//  - Broadcast outputs are pure wires in every state.
// CONFIGURATION
//  Macro WB_DECODER_TIMEOUT_EN:
//  - Defined: a 16-bit wdog counts ACTIVE cycles and is cleared on entering ACTIVE.
//    - When wdog==TIMEOUT-1 with no slave response, ERR_O=1 that cycle and CYC_O/STB_O drop the next cycle -> IDLE.
//    - A slave response in that same cycle has priority over the timeout.
//  - Undefined: no counter; ACTIVE waits indefinitely; ERR_O comes only from ERR_S or DECERR.
// STRUCTURE
//  - Package wb_pkg:
//    - WB_NSLV_MAX=4 and the slave-index width (2)
//    - state encoding localparams ST_IDLE/ST_ACTIVE/ST_DECERR
//    - wdog width (16)
//  - Sub-module wb_watchdog (clear, enable, limit -> expire pulse), instantiated only under WB_DECODER_TIMEOUT_EN.
//  - The response/data muxes and one-hot strobe decode stay inline.
// TESTING
//  1. Read of slave 2: ADR_I=0x8000_0010; ACK_S[2] in the 3rd ACTIVE cycle with DAT_S lane2=0xDEADBEEF
//     -> STB_O=4'b0100 from cycle 2; ACK_O=1, DAT_O=0xDEADBEEF in that cycle; other lanes 0.
//  2. NSLV=3, ADR_I=0xC000_0000 -> STB_O stays 0; ERR_O=1 for exactly one cycle at cycle 2; back to IDLE.
//  3. Stray responses: ACK_S[1]=1 while sel_q=0, then ERR_S[0]=1 with ACK_S[0]=1 -> stray ACK ignored; ERR_O=1, ACK_O=0.
//  4. WB_DECODER_TIMEOUT_EN with TIMEOUT=8 and a slave that never responds
//     -> ERR_O=1 in the 8th ACTIVE cycle; STB_O=0 next cycle. Without the macro: no ERR after 1000 cycles.
//  5. CYC_I dropped in the 2nd ACTIVE cycle, then RST pulsed mid-transfer -> IDLE, no ACK/ERR, all outputs 0.

Source files
------------

// File: rtl/wishbone_slave_decoder_pkg.sv
// Shared constants and types for the Wishbone slave-side address decoder.
//   WB_NSLV_MAX : number of slave lanes on the decoder
//   WB_IDX_W    : width of the slave index taken from the top address bits
//   WB_WDOG_W   : width of the optional watchdog counter
//   state_t     : decoder FSM encoding (ST_IDLE / ST_ACTIVE / ST_DECERR)
package wb_pkg;

    localparam int unsigned WB_NSLV_MAX = 4;
    localparam int unsigned WB_IDX_W    = 2;
    localparam int unsigned WB_WDOG_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DECERR = 2'd2
    } state_t;

endpackage

// File: rtl/wishbone_slave_decoder_if.sv
// Bus bundle between the granted master and the slave lanes.
//   master side : CYC_I/STB_I/WE_I/ADR_I/DAT_I/SEL_I in, DAT_O/ACK_O/ERR_O out
//   slave side  : CYC_O/STB_O one-hot, broadcast WE_O/ADR_O/DAT_SO/SEL_O,
//                 ACK_S/ERR_S/DAT_S returned per lane
// Modport slave is the decoder's view; modport master is the environment's view.
interface wishbone_slave_decoder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import wb_pkg::*;

    localparam int unsigned SEL_W = DATA_W / 8;

    logic                          CYC_I;
    logic                          STB_I;
    logic                          WE_I;
    logic [ADDR_W-1:0]             ADR_I;
    logic [DATA_W-1:0]             DAT_I;
    logic [SEL_W-1:0]              SEL_I;
    logic [DATA_W-1:0]             DAT_O;
    logic                          ACK_O;
    logic                          ERR_O;
    logic [WB_NSLV_MAX-1:0]        CYC_O;
    logic [WB_NSLV_MAX-1:0]        STB_O;
    logic                          WE_O;
    logic [ADDR_W-1:0]             ADR_O;
    logic [DATA_W-1:0]             DAT_SO;
    logic [SEL_W-1:0]              SEL_O;
    logic [WB_NSLV_MAX-1:0]        ACK_S;
    logic [WB_NSLV_MAX-1:0]        ERR_S;
    logic [WB_NSLV_MAX*DATA_W-1:0] DAT_S;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, ACK_S, ERR_S, DAT_S,
        output DAT_O, ACK_O, ERR_O, CYC_O, STB_O, WE_O, ADR_O, DAT_SO, SEL_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, ACK_S, ERR_S, DAT_S,
        input  DAT_O, ACK_O, ERR_O, CYC_O, STB_O, WE_O, ADR_O, DAT_SO, SEL_O
    );

endinterface

// File: rtl/wishbone_slave_decoder_watchdog.sv
// Cycle watchdog: counts enabled cycles, pulses expire_c on the cycle the
// count reaches limit-1 (i.e. the limit-th enabled cycle).
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count (takes priority over enable)
//   enable    : count this cycle
//   limit     : cycle limit, 1..2**W-1
//   expire_c  : combinational expire pulse
module wb_watchdog #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire_c
);

    logic [W-1:0] cnt;

    // Cycle counter
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire_c = enable && (cnt == W'(limit - W'(1)));

endmodule

// File: rtl/wishbone_slave_decoder.sv
// Wishbone slave-side decoder: routes the granted master's transfer to one of
// up to 4 slaves selected by ADR_I[ADDR_W-1 -: 2], and returns that slave's
// ACK/ERR/read data. Unmapped indices get a one-cycle ERR.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : wishbone_slave_decoder_if.slave (master bus + slave lanes)
// Optional macro WB_DECODER_TIMEOUT_EN adds a watchdog that errors out a
// transfer after TIMEOUT ACTIVE cycles without a slave response.
module wishbone_slave_decoder
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    wishbone_slave_decoder_if.slave  bus
);

    state_t                state;
    state_t                state_nxt;
    logic [WB_IDX_W-1:0]   sel_q;
    logic [WB_IDX_W-1:0]   idx_c;
    logic                  mapped_c;
    logic                  wdog_expire_c;

    logic [WB_NSLV_MAX-1:0] cyc_c;
    logic [WB_NSLV_MAX-1:0] stb_c;
    logic                   ack_c;
    logic                   err_c;
    logic [DATA_W-1:0]      dat_c;

    assign idx_c    = bus.ADR_I[ADDR_W-1 -: WB_IDX_W];
    assign mapped_c = (32'(idx_c) < NSLV);

`ifdef WB_DECODER_TIMEOUT_EN
    // Counter is held clear outside ACTIVE, so it restarts on every entry
    wb_watchdog #(
        .W (WB_WDOG_W)
    ) u_wdog (
        .clk      (CLK),
        .rst      (RST),
        .clear    (state != ST_ACTIVE),
        .enable   (state == ST_ACTIVE),
        .limit    (WB_WDOG_W'(TIMEOUT)),
        .expire_c (wdog_expire_c)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^WB_WDOG_W'(TIMEOUT);
    assign wdog_expire_c  = 1'b0;
`endif

    // State and selected-slave registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.CYC_I && bus.STB_I) begin
                sel_q <= idx_c;
            end
        end
    end

    // Next state, one-hot strobes and response mux
    always_comb begin
        state_nxt = state;
        cyc_c     = '0;
        stb_c     = '0;
        ack_c     = 1'b0;
        err_c     = 1'b0;
        dat_c     = '0;
        case (state)
            ST_IDLE: begin
                if (bus.CYC_I && bus.STB_I) begin
                    state_nxt = mapped_c ? ST_ACTIVE : ST_DECERR;
                end
            end
            ST_ACTIVE: begin
                cyc_c[sel_q] = bus.CYC_I;
                stb_c[sel_q] = bus.STB_I;
                // A dropped CYC aborts silently; ERR beats ACK; a response beats the watchdog
                if (!bus.CYC_I) begin
                    state_nxt = ST_IDLE;
                end else if (bus.ERR_S[sel_q]) begin
                    err_c     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bus.ACK_S[sel_q]) begin
                    ack_c     = 1'b1;
                    dat_c     = bus.DAT_S[int'(sel_q)*DATA_W +: DATA_W];
                    state_nxt = ST_IDLE;
                end else if (wdog_expire_c) begin
                    err_c     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DECERR: begin
                err_c     = bus.CYC_I;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Reset is synchronous, so outputs are forced quiet during the reset cycle itself
        if (RST) begin
            cyc_c = '0;
            stb_c = '0;
            ack_c = 1'b0;
            err_c = 1'b0;
            dat_c = '0;
        end
    end

    assign bus.CYC_O  = cyc_c;
    assign bus.STB_O  = stb_c;
    assign bus.ACK_O  = ack_c;
    assign bus.ERR_O  = err_c;
    assign bus.DAT_O  = dat_c;

    assign bus.WE_O   = bus.WE_I;
    assign bus.ADR_O  = bus.ADR_I;
    assign bus.DAT_SO = bus.DAT_I;
    assign bus.SEL_O  = bus.SEL_I;

endmodule

// File: tb/tb_wishbone_slave_decoder.sv
// Directed bench for wishbone_slave_decoder (NSLV=3, TIMEOUT=8): a per-cycle
// vector table plus a hand-written watchdog sequence.
module tb_wishbone_slave_decoder;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NSLV    = 3;
    localparam int unsigned TIMEOUT = 8;
    localparam int          NVEC    = 30;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int checks = 0;
    int errors = 0;

    wishbone_slave_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wishbone_slave_decoder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        cyc;
        logic        stb;
        logic [31:0] adr;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [3:0]  e_cyc;
        logic [3:0]  e_stb;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.ADR_I = '0;
        bus.DAT_I = '0;
        bus.SEL_I = '0;
        bus.ACK_S = '0;
        bus.ERR_S = '0;
        bus.DAT_S = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h00C0_FFEE};

        //          rst  cyc  stb  adr           ack    err    e_cyc  e_stb  ack  err  e_dat
        vecs[0]  = '{1'b1,1'b1,1'b1,32'h8000_0010,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,1'b0,32'h0000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // read of slave 2, ACK in 3rd ACTIVE cycle
        vecs[2]  = '{1'b0,1'b1,1'b1,32'h8000_0010,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b1,1'b1,32'h8000_0010,4'h0,4'h0,4'h4,4'h4,1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b1,1'b1,32'h8000_0010,4'h0,4'h0,4'h4,4'h4,1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b1,1'b1,32'h8000_0010,4'h4,4'h0,4'h4,4'h4,1'b1,1'b0,32'hDEAD_BEEF};
        vecs[6]  = '{1'b0,1'b0,1'b0,32'h8000_0010,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // unmapped index 3: one ERR cycle, no strobe
        vecs[7]  = '{1'b0,1'b1,1'b1,32'hC000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b1,1'b1,32'hC000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b1,32'h0};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'hC000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // slave 0: stray lanes ignored, then ACK+ERR together -> ERR only
        vecs[10] = '{1'b0,1'b1,1'b1,32'h0000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[11] = '{1'b0,1'b1,1'b1,32'h0000_0000,4'h2,4'h4,4'h1,4'h1,1'b0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b1,1'b1,32'h0000_0000,4'h1,4'h1,4'h1,4'h1,1'b0,1'b1,32'h0};
        vecs[13] = '{1'b0,1'b0,1'b0,32'h0000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // slave 1: CYC dropped in 2nd ACTIVE cycle while slave responds
        vecs[14] = '{1'b0,1'b1,1'b1,32'h4000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[15] = '{1'b0,1'b1,1'b1,32'h4000_0000,4'h0,4'h0,4'h2,4'h2,1'b0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b0,1'b0,32'h4000_0000,4'h2,4'h2,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,1'b0,32'h4000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // RST mid-transfer drops the in-flight ACK
        vecs[18] = '{1'b0,1'b1,1'b1,32'h4000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[19] = '{1'b0,1'b1,1'b1,32'h4000_0000,4'h0,4'h0,4'h2,4'h2,1'b0,1'b0,32'h0};
        vecs[20] = '{1'b1,1'b1,1'b1,32'h4000_0000,4'h2,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[21] = '{1'b0,1'b1,1'b1,32'h4000_0000,4'h2,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[22] = '{1'b0,1'b0,1'b0,32'h4000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[23] = '{1'b0,1'b0,1'b0,32'h0000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        // back-to-back: STB held after ACK re-decodes through IDLE
        vecs[24] = '{1'b0,1'b1,1'b1,32'h8000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[25] = '{1'b0,1'b1,1'b1,32'h8000_0000,4'h4,4'h0,4'h4,4'h4,1'b1,1'b0,32'hDEAD_BEEF};
        vecs[26] = '{1'b0,1'b1,1'b1,32'h8000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};
        vecs[27] = '{1'b0,1'b1,1'b1,32'h8000_0000,4'h0,4'h0,4'h4,4'h4,1'b0,1'b0,32'h0};
        vecs[28] = '{1'b0,1'b1,1'b1,32'h8000_0000,4'h4,4'h0,4'h4,4'h4,1'b1,1'b0,32'hDEAD_BEEF};
        vecs[29] = '{1'b0,1'b0,1'b0,32'h0000_0000,4'h0,4'h0,4'h0,4'h0,1'b0,1'b0,32'h0};

        for (int i = 0; i < NVEC; i++) begin
            tick();
            RST       = vecs[i].rst;
            bus.CYC_I = vecs[i].cyc;
            bus.STB_I = vecs[i].stb;
            bus.ADR_I = vecs[i].adr;
            bus.ACK_S = vecs[i].ack;
            bus.ERR_S = vecs[i].err;
            bus.WE_I  = i[0];
            bus.DAT_I = 32'hA500_0000 | 32'(i);
            bus.SEL_I = 4'(i);
            #1;
            chk($sformatf("v%0d cyc_o", i), 32'(bus.CYC_O), 32'(vecs[i].e_cyc));
            chk($sformatf("v%0d stb_o", i), 32'(bus.STB_O), 32'(vecs[i].e_stb));
            chk($sformatf("v%0d ack_o", i), 32'(bus.ACK_O), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d err_o", i), 32'(bus.ERR_O), 32'(vecs[i].e_err));
            chk($sformatf("v%0d dat_o", i), bus.DAT_O, vecs[i].e_dat);
            chk($sformatf("v%0d adr_bcast", i), bus.ADR_O, vecs[i].adr);
            chk($sformatf("v%0d dat_bcast", i), bus.DAT_SO, 32'hA500_0000 | 32'(i));
            chk($sformatf("v%0d we_sel_bcast", i), 32'({bus.WE_O, bus.SEL_O}), 32'({i[0], 4'(i)}));
        end

        // Non-responding slave 0, request held throughout
        tick();
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.ADR_I = 32'h0000_0000;
        bus.ACK_S = '0;
        bus.ERR_S = '0;
        #1;
        chk("wd idle stb", 32'(bus.STB_O), 32'h0);
`ifdef WB_DECODER_TIMEOUT_EN
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 1; k <= int'(TIMEOUT); k++) begin
                tick();
                chk($sformatf("wd r%0d c%0d stb", rep, k), 32'(bus.STB_O), 32'h1);
                chk($sformatf("wd r%0d c%0d err", rep, k), 32'(bus.ERR_O), (k == int'(TIMEOUT)) ? 32'h1 : 32'h0);
            end
            tick();
            chk($sformatf("wd r%0d after stb", rep), 32'(bus.STB_O), 32'h0);
            chk($sformatf("wd r%0d after err", rep), 32'(bus.ERR_O), 32'h0);
        end
`else
        begin
            int err_seen;
            int stb_lost;
            err_seen = 0;
            stb_lost = 0;
            for (int k = 1; k <= 1000; k++) begin
                tick();
                if (bus.ERR_O !== 1'b0) err_seen++;
                if (bus.STB_O !== 4'h1) stb_lost++;
            end
            chk("nowd err cycles", 32'(err_seen), 32'h0);
            chk("nowd stb lost cycles", 32'(stb_lost), 32'h0);
        end
`endif
        tick();
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        #1;
        chk("wd abort stb", 32'(bus.STB_O), 32'h0);
        chk("wd abort err", 32'(bus.ERR_O), 32'h0);
        tick();
        chk("wd final idle cyc", 32'(bus.CYC_O), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
